// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Imported by the baud tick generator and the TX FIFO controller.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam int   CLK_DIV_DEF   = 434;
    localparam int   BAUD_W_DEF    = $clog2(CLK_DIV_DEF);

    function automatic int baud_w(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLK_DIV-1, ticks on the last clock
// of each bit, and restarts from zero on a synchronous clear.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int  CLK_DIV = CLK_DIV_DEF,
    localparam int CW      = baud_w(CLK_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tick
);

    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Pops bytes from the TX scfifo and shifts them out on ser_tx as
// 8N1 frames (optional even parity), back-to-back when data is queued.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter bit PARITY_EN = 1'b0,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rdreq,
    output logic              ser_tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CW = baud_w(CLK_DIV);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] PRE_LAST = CW'(CLK_DIV - 2);
    localparam logic [IW-1:0] BIT_LAST = IW'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [IW-1:0]     bit_idx;
    logic              parity;
    logic              tick;
    logic              baud_clr;
    logic [CW-1:0]     baud_cnt;
    logic              next_ok;

    assign baud_clr   = (state == IDLE) || (state == FETCH) || (state == LOAD);
    assign fifo_rdreq = (state == FETCH);
    assign next_ok    = tx_en && !fifo_empty;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clr   (baud_clr),
        .count (baud_cnt),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ser_tx  <= UART_IDLE_LVL;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            bit_idx <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
        end else begin
            // registered so the pulse lands on the final stop-bit clock
            tx_done <= (state == STOP) && (baud_cnt == PRE_LAST);
            unique case (state)
                IDLE: begin
                    if (next_ok) begin
                        state   <= FETCH;
                        tx_busy <= 1'b1;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shreg   <= fifo_q;
                    parity  <= ^fifo_q;
                    bit_idx <= '0;
                    ser_tx  <= ~UART_IDLE_LVL;
                    state   <= START;
                end
                START: begin
                    if (tick) begin
                        ser_tx <= shreg[0];
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == BIT_LAST) begin
                            if (PARITY_EN) begin
                                ser_tx <= parity;
                                state  <= PARITY;
                            end else begin
                                ser_tx <= UART_IDLE_LVL;
                                state  <= STOP;
                            end
                        end else begin
                            shreg   <= shreg >> 1;
                            ser_tx  <= shreg[1];
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        ser_tx <= UART_IDLE_LVL;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (next_ok) begin
                            state <= FETCH;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_no_pop_empty: assert property (
        @(posedge clk) disable iff (rst) fifo_rdreq |-> !fifo_empty
    );

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scoreboard bench: FIFO models feed two controllers (no parity, parity)
// and a bit-level receiver decodes each frame against queued expectations.
module tb_uart_tx_fifo_ctrl;

    localparam int DIV = 4;

    typedef struct {
        logic [7:0] data;
        int         gap;
        int         lat;
        int         t_push;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tx_en0, tx_en1;
    logic       fifo_empty0, fifo_empty1;
    logic [7:0] fifo_q0, fifo_q1;
    logic       fifo_rdreq0, fifo_rdreq1;
    logic       ser_tx0, ser_tx1;
    logic       tx_busy0, tx_busy1;
    logic       tx_done0, tx_done1;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_rd0 = 0;
    int   n_rd1 = 0;
    int   wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    logic [7:0] fmem0[64];
    logic [7:0] fmem1[64];
    exp_t exp0[$];
    exp_t exp1[$];

    uart_tx_fifo_ctrl #(
        .CLK_DIV   (DIV),
        .PARITY_EN (1'b0),
        .DATA_W    (8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en0),
        .fifo_empty (fifo_empty0),
        .fifo_q     (fifo_q0),
        .fifo_rdreq (fifo_rdreq0),
        .ser_tx     (ser_tx0),
        .tx_busy    (tx_busy0),
        .tx_done    (tx_done0)
    );

    uart_tx_fifo_ctrl #(
        .CLK_DIV   (DIV),
        .PARITY_EN (1'b1),
        .DATA_W    (8)
    ) u_dut_p (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en1),
        .fifo_empty (fifo_empty1),
        .fifo_q     (fifo_q1),
        .fifo_rdreq (fifo_rdreq1),
        .ser_tx     (ser_tx1),
        .tx_busy    (tx_busy1),
        .tx_done    (tx_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // legacy-mode FIFO: q valid the cycle after the pop strobe
    assign fifo_empty0 = (rp0 >= wp0);
    assign fifo_empty1 = (rp1 >= wp1);

    always @(posedge clk) begin
        if (fifo_rdreq0) begin
            chk("rd_nonempty0", int'(fifo_empty0), 0);
            n_rd0 <= n_rd0 + 1;
            if (!fifo_empty0) begin
                fifo_q0 <= fmem0[rp0];
                rp0     <= rp0 + 1;
            end
        end
        if (fifo_rdreq1) begin
            chk("rd_nonempty1", int'(fifo_empty1), 0);
            n_rd1 <= n_rd1 + 1;
            if (!fifo_empty1) begin
                fifo_q1 <= fmem1[rp1];
                rp1     <= rp1 + 1;
            end
        end
    end

    task automatic push(input int i, input logic [7:0] b,
                        input int gap, input int lat);
        exp_t e;
        e.data   = b;
        e.gap    = gap;
        e.lat    = lat;
        e.t_push = cyc;
        if (i == 0) begin
            fmem0[wp0] = b;
            wp0++;
            exp0.push_back(e);
        end else begin
            fmem1[wp1] = b;
            wp1++;
            exp1.push_back(e);
        end
    endtask

    function automatic logic get_tx(input int i);
        return (i == 0) ? ser_tx0 : ser_tx1;
    endfunction

    function automatic logic get_done(input int i);
        return (i == 0) ? tx_done0 : tx_done1;
    endfunction

    function automatic logic get_busy(input int i);
        return (i == 0) ? tx_busy0 : tx_busy1;
    endfunction

    task automatic rx_mon(input int i);
        exp_t       e;
        logic [10:0] bits;
        logic       v;
        bit         abort;
        int         nb, start, last_end;
        int         glitch, done_pos, done_cnt, busy_lo;
        nb       = (i == 0) ? 10 : 11;
        last_end = -100;
        forever begin
            @(negedge clk);
            if (rst || get_tx(i) !== 1'b0) continue;
            start    = cyc;
            bits     = '0;
            glitch   = 0;
            done_pos = -1;
            done_cnt = 0;
            busy_lo  = 0;
            abort    = 1'b0;
            for (int c = 0; c < nb * DIV && !abort; c++) begin
                if (c > 0) @(negedge clk);
                if (rst) begin
                    abort = 1'b1;
                end else begin
                    v = get_tx(i);
                    if (c % DIV == 0) bits[c / DIV] = v;
                    else if (v !== bits[c / DIV]) glitch++;
                    if (get_done(i) === 1'b1) begin
                        done_cnt++;
                        done_pos = c;
                    end
                    if (get_busy(i) !== 1'b1) busy_lo++;
                end
            end
            if ((i == 0 ? exp0.size() : exp1.size()) == 0) begin
                chk("sb_unexpected", 1, 0);
                continue;
            end
            e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
            if (abort) begin
                last_end = -100;
                continue;
            end
            chk("start_bit", int'(bits[0]), 0);
            chk("data", int'(bits[8:1]), int'(e.data));
            if (i == 1) chk("parity", int'(bits[9]), int'(^e.data));
            chk("stop_bit", int'(bits[nb-1]), 1);
            chk("bit_glitch", glitch, 0);
            chk("done_pos", done_pos, nb * DIV - 1);
            chk("done_cnt", done_cnt, 1);
            chk("busy_frame", busy_lo, 0);
            if (e.gap >= 0) chk("idle_gap", start - last_end - 1, e.gap);
            if (e.lat >= 0) chk("latency", start - e.t_push, e.lat);
            last_end = start + nb * DIV - 1;
        end
    endtask

    initial rx_mon(0);
    initial rx_mon(1);

    function automatic bit cond(input int w);
        case (w)
            0:       return tx_done0 === 1'b1;
            1:       return ser_tx0 === 1'b0;
            2:       return exp0.size() == 0 && tx_busy0 === 1'b0;
            3:       return exp1.size() == 0 && tx_busy1 === 1'b0;
            default: return tx_busy0 === 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int w, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!cond(w) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(n >= limit), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int low_cnt;
        rst    = 1'b1;
        tx_en0 = 1'b0;
        tx_en1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ser_tx0", int'(ser_tx0), 1);
        chk("rst_busy0", int'(tx_busy0), 0);
        chk("rst_done0", int'(tx_done0), 0);
        chk("rst_rdreq0", int'(fifo_rdreq0), 0);
        chk("rst_ser_tx1", int'(ser_tx1), 1);
        chk("rst_busy1", int'(tx_busy1), 0);
        @(posedge clk) #1;
        rst    = 1'b0;
        tx_en0 = 1'b1;
        tx_en1 = 1'b1;

        // single byte, 8N1
        @(posedge clk) #1;
        r0 = n_rd0;
        push(0, 8'hA5, -1, 3);
        wait_for("t1_done_to", 0, 100);
        @(negedge clk);
        chk("t1_busy_fall", int'(tx_busy0), 0);
        chk("t1_rdreq", n_rd0 - r0, 1);

        // back-to-back pair
        @(posedge clk) #1;
        r0 = n_rd0;
        push(0, 8'h00, -1, 3);
        push(0, 8'hFF, 2, -1);
        wait_for("t2_drain_to", 2, 300);
        chk("t2_rdreq", n_rd0 - r0, 2);
        chk("t2_empty", int'(fifo_empty0), 1);
        chk("t2_idle", int'(tx_busy0), 0);

        // even parity
        @(posedge clk) #1;
        r0 = n_rd1;
        push(1, 8'h07, -1, 3);
        push(1, 8'h3C, 2, -1);
        wait_for("t3_drain_to", 3, 300);
        chk("t3_rdreq", n_rd1 - r0, 2);

        // reset in data bit 3, then a clean frame
        @(posedge clk) #1;
        push(0, 8'h55, -1, 3);
        wait_for("t4_start_to", 1, 50);
        @(posedge clk) #1;
        push(0, 8'hC3, -1, -1);
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        r0  = n_rd0;
        @(posedge clk);
        @(negedge clk);
        chk("t4_rst_ser_tx", int'(ser_tx0), 1);
        chk("t4_rst_busy", int'(tx_busy0), 0);
        chk("t4_rst_rdreq", int'(fifo_rdreq0), 0);
        chk("t4_rst_nopop", n_rd0 - r0, 0);
        @(posedge clk) #1;
        rst = 1'b0;
        wait_for("t4_drain_to", 2, 300);
        chk("t4_rdreq", n_rd0 - r0, 1);

        // tx_en dropped during start bit
        @(posedge clk) #1;
        r0 = n_rd0;
        push(0, 8'h11, -1, 3);
        push(0, 8'h22, -1, -1);
        push(0, 8'h33, 2, -1);
        wait_for("t5_start_to", 1, 50);
        @(posedge clk) #1;
        tx_en0 = 1'b0;
        wait_for("t5_stop_to", 4, 200);
        repeat (20) @(negedge clk);
        chk("t5_rdreq_hold", n_rd0 - r0, 1);
        chk("t5_pending", exp0.size(), 2);
        chk("t5_line_idle", int'(ser_tx0), 1);
        @(posedge clk) #1;
        tx_en0 = 1'b1;
        wait_for("t5_drain_to", 2, 300);
        chk("t5_rdreq", n_rd0 - r0, 3);

        // enabled but empty
        @(posedge clk) #1;
        r0      = n_rd0;
        low_cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (ser_tx0 !== 1'b1) low_cnt++;
        end
        chk("t6_line_low", low_cnt, 0);
        chk("t6_rdreq", n_rd0 - r0, 0);

        chk("sb_left0", exp0.size(), 0);
        chk("sb_left1", exp1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
